// File: rtl/pipe_stage_chain_if.sv
// Bundle of the pipeline-chain handshake, hazard-control and statistics signals.
// The master side is the CPU control/datapath; the slave side is the register chain.
interface pipe_stage_chain_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    logic                   in_valid_i;
    logic [WIDTH-1:0]       in_data_i;
    logic                   in_ready_o;
    logic [DEPTH-1:0]       stall_i;
    logic [DEPTH-1:0]       flush_i;
    logic [DEPTH-1:0]       stage_valid_o;
    logic [DEPTH*WIDTH-1:0] stage_data_o;
    logic                   out_valid_o;
    logic [WIDTH-1:0]       out_data_o;
    logic                   out_ready_i;
    logic                   cnt_clr_i;
    logic [CNT_W-1:0]       retire_cnt_o;
    logic [CNT_W-1:0]       stall_cnt_o;
    logic [CNT_W-1:0]       flush_cnt_o;

    modport master (
        output in_valid_i, in_data_i, stall_i, flush_i, out_ready_i, cnt_clr_i,
        input  in_ready_o, stage_valid_o, stage_data_o, out_valid_o, out_data_o,
               retire_cnt_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  in_valid_i, in_data_i, stall_i, flush_i, out_ready_i, cnt_clr_i,
        output in_ready_o, stage_valid_o, stage_data_o, out_valid_o, out_data_o,
               retire_cnt_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline register chain with per-stage valid, stall, flush and
// bubble collapse, plus saturating retire/stall/flush statistics counters.
module pipe_stage_chain #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic              clk_i,
    input logic              rst_i,
    pipe_stage_chain_if.slave bus
);
    localparam int PW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0]            eff_valid;
    logic [DEPTH-1:0]            hold;
    logic                        hold_chain;
    logic [DEPTH-1:0]            up_valid;
    logic [DEPTH-1:0][WIDTH-1:0] up_data;
    logic                        out_valid;
    logic                        transfer;

    logic [CNT_W-1:0] retire_cnt, stall_cnt, flush_cnt;
    logic [CNT_W-1:0] retire_next, stall_next, flush_next;
    logic [PW-1:0]    flush_inc;
    logic [CNT_W:0]   flush_sum;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Flushed or empty stages never hold, so upstream items collapse into them.
    always_comb begin
        eff_valid     = valid_q & ~bus.flush_i;
        hold          = '0;
        hold_chain    = eff_valid[DEPTH-1] & (bus.stall_i[DEPTH-1] | ~bus.out_ready_i);
        hold[DEPTH-1] = hold_chain;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            hold_chain = eff_valid[k] & (bus.stall_i[k] | hold_chain);
            hold[k]    = hold_chain;
        end
    end

    assign up_valid  = {eff_valid[DEPTH-2:0] & ~hold[DEPTH-2:0], bus.in_valid_i};
    assign up_data   = {data_q[DEPTH-2:0], bus.in_data_i};
    assign out_valid = eff_valid[DEPTH-1] & ~bus.stall_i[DEPTH-1];
    assign transfer  = out_valid & bus.out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!hold[k]) begin
                    valid_q[k] <= up_valid[k];
                    data_q[k]  <= up_data[k];
                end
            end
        end
    end

    always_comb begin
        flush_inc = '0;
        for (int k = 0; k < DEPTH; k++) begin
            flush_inc = flush_inc + PW'(valid_q[k] & bus.flush_i[k]);
        end
        flush_sum   = {1'b0, flush_cnt} + (CNT_W + 1)'(flush_inc);
        flush_next  = flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
        retire_next = sat_inc(retire_cnt, transfer);
        stall_next  = sat_inc(stall_cnt, |hold);
    end

    // Clear wins over any increment in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retire_cnt <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else if (bus.cnt_clr_i) begin
            retire_cnt <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            retire_cnt <= retire_next;
            stall_cnt  <= stall_next;
            flush_cnt  <= flush_next;
        end
    end

    assign bus.in_ready_o    = ~hold[0];
    assign bus.out_valid_o   = out_valid;
    assign bus.out_data_o    = data_q[DEPTH-1];
    assign bus.stage_valid_o = valid_q;
    assign bus.stage_data_o  = data_q;
    assign bus.retire_cnt_o  = retire_cnt;
    assign bus.stall_cnt_o   = stall_cnt;
    assign bus.flush_cnt_o   = flush_cnt;
endmodule
